// File: rtl/vx_tcu_pkg.sv
// -----------------------------------------------------------------------------
// vx_tcu_pkg
// Shared constants and helpers for the TCU dot-product reduction lane (DRL).
//   DRL_GRDW      : guard bits kept below the mantissa LSB during alignment
//   DRL_EXPW/MANW : default exponent / mantissa widths of a product term
//   drl_term_t    : packed {sign, exp, man} product term at default widths
//   drl_sum_width : width of the aligned two's-complement sum of n terms
// -----------------------------------------------------------------------------
package vx_tcu_pkg;

  localparam int DRL_GRDW = 3;
  localparam int DRL_EXPW = 8;
  localparam int DRL_MANW = 24;

  typedef struct packed {
    logic                sign;
    logic [DRL_EXPW-1:0] exp;
    logic [DRL_MANW-1:0] man;
  } drl_term_t;

  // One sign bit plus log2(n) carry bits above the aligned magnitude
  // guarantee the reduction never overflows.
  function automatic int drl_sum_width(input int n, input int manw, input int grdw);
    return manw + grdw + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/vx_tcu_drl_max_exp.sv
// -----------------------------------------------------------------------------
// vx_tcu_drl_max_exp
// Combinational maximum-exponent selection over N biased exponents.
// Ports:
//   exps      in  N*WIDTH  packed exponents, term i at [i*WIDTH +: WIDTH]
//   max_exp   out WIDTH    largest exponent (ties resolve to lowest index)
//   shift_amt out N*8      per-term right shift = max_exp - exp_i, saturating
//                          at 255, term i at [i*8 +: 8]
// -----------------------------------------------------------------------------
module vx_tcu_drl_max_exp #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic [N*WIDTH-1:0] exps,
  output logic [WIDTH-1:0]   max_exp,
  output logic [N*8-1:0]     shift_amt
);

  logic [WIDTH-1:0] max_w;

  // Strict '>' keeps the first (lowest-index) maximum on ties.
  always_comb begin
    max_w = exps[WIDTH-1:0];
    for (int i = 1; i < N; i++) begin
      if (exps[i*WIDTH +: WIDTH] > max_w) begin
        max_w = exps[i*WIDTH +: WIDTH];
      end
    end
  end

  assign max_exp = max_w;

  for (genvar gi = 0; gi < N; gi++) begin : g_shift
    // Widened so the saturation compare is well-formed for any WIDTH.
    logic [WIDTH+7:0] diff;
    assign diff = {8'b0, max_w - exps[gi*WIDTH +: WIDTH]};
    assign shift_amt[gi*8 +: 8] = (diff > (WIDTH+8)'(255)) ? 8'hFF : diff[7:0];
  end

endmodule

// File: rtl/vx_tcu_drl_align_add.sv
// -----------------------------------------------------------------------------
// vx_tcu_drl_align_add
// Elastic 3-stage alignment-and-sum stage of the TCU dot-product reduction lane.
//   S0: registered inputs, max-exponent / shift computation feeds S1
//   S1: registered max_exp + shifts, alignment and reduction feed S2
//   S2: registered sum, exponent and tag presented on the out_* port
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready has no path from in_valid)
//   in_sign  [N]          per-term sign, 1 = negative
//   in_exp   [N*EXPW]     per-term biased exponent, term i at [i*EXPW +: EXPW]
//   in_man   [N*MANW]     per-term unsigned mantissa incl. hidden bit
//   in_tag   [TAGW]       opaque sideband carried with the beat
//   out_valid/out_ready   output handshake, out_* held while stalled
//   out_exp  [EXPW]       maximum exponent of the beat
//   out_sum  [SUMW]       two's-complement aligned sum, LSB = 2^-(MANW-1+GRDW)
//   out_tag  [TAGW]       tag of the beat
// -----------------------------------------------------------------------------
module vx_tcu_drl_align_add
  import vx_tcu_pkg::*;
#(
  parameter int N    = 5,
  parameter int EXPW = 8,
  parameter int MANW = 24,
  parameter int GRDW = DRL_GRDW,
  parameter int TAGW = 8,
  localparam int SUMW = drl_sum_width(N, MANW, GRDW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_sign,
  input  logic [N*EXPW-1:0] in_exp,
  input  logic [N*MANW-1:0] in_man,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXPW-1:0]   out_exp,
  output logic [SUMW-1:0]   out_sum,
  output logic [TAGW-1:0]   out_tag
);

  localparam int EXTW = MANW + GRDW;

  // ---------------------------------------------------------------------------
  // Stage control: a stage advances when it is empty or its successor advances.
  // ---------------------------------------------------------------------------
  logic v0_reg, v1_reg, v2_reg;
  logic adv0, adv1, adv2;

  assign adv2     = ~v2_reg | out_ready;
  assign adv1     = ~v1_reg | adv2;
  assign adv0     = ~v0_reg | adv1;
  assign in_ready = adv0;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_reg <= 1'b0;
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (adv0) v0_reg <= in_valid;
      if (adv1) v1_reg <= v0_reg;
      if (adv2) v2_reg <= v1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: registered inputs and max-exponent selection
  // ---------------------------------------------------------------------------
  logic [N-1:0]      sign0_reg;
  logic [N*EXPW-1:0] exp0_reg;
  logic [N*MANW-1:0] man0_reg;
  logic [TAGW-1:0]   tag0_reg;
  logic [EXPW-1:0]   max_exp_s0;
  logic [N*8-1:0]    shift_s0;

  vx_tcu_drl_max_exp #(
    .N     (N),
    .WIDTH (EXPW)
  ) u_max_exp (
    .exps      (exp0_reg),
    .max_exp   (max_exp_s0),
    .shift_amt (shift_s0)
  );

  // ---------------------------------------------------------------------------
  // S1: registered shifts, alignment with guard/sticky, signed reduction
  // ---------------------------------------------------------------------------
  logic [N-1:0]      sign1_reg;
  logic [N*MANW-1:0] man1_reg;
  logic [TAGW-1:0]   tag1_reg;
  logic [EXPW-1:0]   max_exp1_reg;
  logic [N*8-1:0]    shift1_reg;

  logic [SUMW-1:0]   term_val [N];
  logic [SUMW-1:0]   sum_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_align
    logic [MANW-1:0] man_w;
    logic [7:0]      sh;
    logic [EXTW-1:0] ext;
    logic [EXTW-1:0] mag;
    logic [SUMW-1:0] mag_ext;

    assign man_w = man1_reg[gi*MANW +: MANW];
    assign sh    = shift1_reg[gi*8 +: 8];
    assign ext   = {man_w, {GRDW{1'b0}}};

    always_comb begin
      mag = '0;
      if (int'(sh) >= EXTW) begin
        // Everything shifted out: only a nonzero mantissa survives as sticky.
        mag = EXTW'(|man_w);
      end else begin
        // Bits pushed left by (EXTW - sh) are exactly the ones lost on the right.
        mag = (ext >> sh) | EXTW'(|(ext << 32'(EXTW - int'(sh))));
      end
    end

    assign mag_ext      = {{(SUMW-EXTW){1'b0}}, mag};
    assign term_val[gi] = sign1_reg[gi] ? (~mag_ext + SUMW'(1)) : mag_ext;
  end

  // Modular two's-complement accumulation; SUMW leaves room for every carry.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < N; i++) begin
      sum_next = sum_next + term_val[i];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: output registers
  // ---------------------------------------------------------------------------
  logic [SUMW-1:0] sum2_reg;
  logic [EXPW-1:0] exp2_reg;
  logic [TAGW-1:0] tag2_reg;

  // Data registers carry no reset; validity is tracked solely by v*_reg.
  always_ff @(posedge clk) begin
    if (adv0) begin
      sign0_reg <= in_sign;
      exp0_reg  <= in_exp;
      man0_reg  <= in_man;
      tag0_reg  <= in_tag;
    end
    if (adv1) begin
      sign1_reg    <= sign0_reg;
      man1_reg     <= man0_reg;
      tag1_reg     <= tag0_reg;
      max_exp1_reg <= max_exp_s0;
      shift1_reg   <= shift_s0;
    end
    if (adv2) begin
      sum2_reg <= sum_next;
      exp2_reg <= max_exp1_reg;
      tag2_reg <= tag1_reg;
    end
  end

  assign out_valid = v2_reg;
  assign out_exp   = exp2_reg;
  assign out_sum   = sum2_reg;
  assign out_tag   = tag2_reg;

endmodule

// File: tb/tb_vx_tcu_drl_align_add.sv
// -----------------------------------------------------------------------------
// tb_vx_tcu_drl_align_add
// Directed self-checking bench for vx_tcu_drl_align_add (default parameters:
// N=5, EXPW=8, MANW=24, GRDW=3, TAGW=8, SUMW=31). Inputs change on the falling
// edge, outputs are sampled 1 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_vx_tcu_drl_align_add;

  localparam int N    = 5;
  localparam int EXPW = 8;
  localparam int MANW = 24;
  localparam int TAGW = 8;
  localparam int SUMW = 31;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_sign;
  logic [N*EXPW-1:0] in_exp;
  logic [N*MANW-1:0] in_man;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [EXPW-1:0]   out_exp;
  logic [SUMW-1:0]   out_sum;
  logic [TAGW-1:0]   out_tag;

  int total = 0;
  int bad   = 0;
  int sent;
  int recv;

  vx_tcu_drl_align_add dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_sum   (out_sum),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_terms();
    in_sign = '0;
    in_exp  = '0;
    in_man  = '0;
  endtask

  task automatic set_term(input int i, input logic s, input logic [EXPW-1:0] e,
                          input logic [MANW-1:0] m);
    in_sign[i]             = s;
    in_exp[i*EXPW +: EXPW] = e;
    in_man[i*MANW +: MANW] = m;
  endtask

  // Called on a falling edge with terms already set. Pushes one beat with
  // out_ready=1 and checks the 3-stage latency plus the result.
  task automatic run_beat(input string name, input logic [TAGW-1:0] tagv,
                          input logic [EXPW-1:0] xe, input logic [SUMW-1:0] xs);
    in_tag   = tagv;
    in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);                       // accept edge k
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({name, "_lat_k"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({name, "_lat_k1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    // valid after edge k+2, consumed by downstream at edge k+3
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_exp"},   64'(out_exp),   64'(xe));
    check({name, "_sum"},   64'(out_sum),   64'(xs));
    check({name, "_tag"},   64'(out_tag),   64'(tagv));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_tag    = '0;
    clear_terms();

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("post_reset_in_ready",  64'(in_ready),  64'd1);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);

    // ---------------- directed vectors ----------------
    clear_terms();
    for (int i = 0; i < N; i++) set_term(i, 1'b0, 8'd10, 24'h800000);
    run_beat("equal_exp", 8'h11, 8'd10, 31'h14000000);

    clear_terms();
    set_term(0, 1'b0, 8'd20, 24'h800000);
    set_term(1, 1'b0, 8'd18, 24'h800000);
    run_beat("offset", 8'h22, 8'd20, 31'h05000000);

    clear_terms();
    set_term(0, 1'b0, 8'd20, 24'h800000);
    set_term(1, 1'b0, 8'd16, 24'h800001);
    run_beat("sticky", 8'h33, 8'd20, 31'h04400001);

    clear_terms();
    set_term(0, 1'b0, 8'd255, 24'h800000);
    set_term(1, 1'b0, 8'd0,   24'h000001);
    run_beat("large_shift", 8'h44, 8'd255, 31'h04000001);

    clear_terms();
    set_term(0, 1'b0, 8'd50, 24'hC00000);
    set_term(1, 1'b1, 8'd50, 24'hC00000);
    run_beat("cancel", 8'h55, 8'd50, 31'h00000000);

    // negative addend after a shift of 1: 0x4000000 - 0x2000000
    clear_terms();
    set_term(0, 1'b0, 8'd30, 24'h800000);
    set_term(3, 1'b1, 8'd29, 24'h800000);
    run_beat("mixed_sign", 8'h66, 8'd30, 31'h02000000);

    // lone negative term, maximum in the last slot: -0x4000000 mod 2^31
    clear_terms();
    set_term(4, 1'b1, 8'd10, 24'h800000);
    run_beat("negative", 8'h77, 8'd10, 31'h7C000000);

    // ---------------- backpressure stream ----------------
    // Each beat: term0 (+, exp tag+1), term2 (-, exp tag) -> sum 0x2000000.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 7);
      clear_terms();
      if (sent < 8) begin
        in_valid = 1'b1;
        in_tag   = TAGW'(sent);
        set_term(0, 1'b0, EXPW'(sent + 1), 24'h800000);
        set_term(2, 1'b1, EXPW'(sent),     24'h800000);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("bp_in_ready_c2", 64'(in_ready), 64'd1);
      if (c == 3) begin
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_held_beats",    64'(sent),     64'd3);
      end
      if (c >= 3 && c <= 7) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_tag",   64'(out_tag),   64'd0);
        check("bp_hold_sum",   64'(out_sum),   64'h2000000);
      end
      if (out_valid && out_ready) begin
        check("bp_tag", 64'(out_tag), 64'(recv));
        check("bp_exp", 64'(out_exp), 64'(recv + 1));
        check("bp_sum", 64'(out_sum), 64'h2000000);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    check("bp_sent_count", 64'(sent), 64'd8);
    check("bp_recv_count", 64'(recv), 64'd8);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      clear_terms();
      set_term(0, 1'b0, 8'd5, 24'h800000);
      in_tag   = TAGW'(8'hA0 + b);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("mid_full_valid", 64'(out_valid), 64'd1);
    check("mid_full_tag",   64'(out_tag),   64'hA0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("mid_no_leftover", 64'(out_valid), 64'd0);
    end
    check("mid_in_ready", 64'(in_ready), 64'd1);

    // recovery after reset
    clear_terms();
    set_term(1, 1'b0, 8'd40, 24'hA00000);
    set_term(2, 1'b0, 8'd39, 24'h800000);
    run_beat("recover", 8'hBB, 8'd40, 31'h07000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
